// File: rtl/du_dump_sequencer_if.sv
// Bus bundle between the dump sequencer and its surroundings (debug_unit trigger,
// UART TX handshake, data-path debug read ports).
//   master : sequencer side (drives o_*, samples i_*)
//   slave  : environment side (drives i_*, samples o_*)
interface du_dump_sequencer_if #(
  parameter int unsigned BYTE    = 8,
  parameter int unsigned DWORD   = 32,
  parameter int unsigned RB_ADDR = 5,
  parameter int unsigned DM_ADDR = 5
);
  logic               i_start;
  logic               i_tx_done;
  logic [DWORD-1:0]   i_pc_value;
  logic [DWORD-1:0]   i_rb_data;
  logic [DWORD-1:0]   i_dm_data;
  logic [RB_ADDR-1:0] o_rb_addr;
  logic               o_rb_read_enable;
  logic [DM_ADDR-1:0] o_dm_addr;
  logic               o_dm_read_enable;
  logic               o_dm_du_flag;
  logic [BYTE-1:0]    o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_done;

  modport master (
    input  i_start, i_tx_done, i_pc_value, i_rb_data, i_dm_data,
    output o_rb_addr, o_rb_read_enable, o_dm_addr, o_dm_read_enable,
           o_dm_du_flag, o_tx_data, o_tx_start, o_busy, o_done
  );

  modport slave (
    output i_start, i_tx_done, i_pc_value, i_rb_data, i_dm_data,
    input  o_rb_addr, o_rb_read_enable, o_dm_addr, o_dm_read_enable,
           o_dm_du_flag, o_tx_data, o_tx_start, o_busy, o_done
  );
endinterface

// File: rtl/du_dump_sequencer.sv
// Post-halt state dump: PC, then every register-bank word, then every data-memory
// word, each sent as 4 bytes MSB first over the UART TX start/done handshake.
// Ports:
//   i_clock, i_reset : clock, asynchronous active-low reset
//   bus (master)     : i_start trigger, UART TX start/data/done, register-bank and
//                      data-memory debug read ports, o_busy / o_done status
// All outputs are registered: each transition loads the outputs of the state
// being entered.
module du_dump_sequencer #(
  parameter int unsigned BYTE    = 8,
  parameter int unsigned DWORD   = 32,
  parameter int unsigned RB_ADDR = 5,
  parameter int unsigned DM_ADDR = 5
) (
  input  logic                i_clock,
  input  logic                i_reset,
  du_dump_sequencer_if.master bus
);

  localparam int unsigned BCNT_W = 2;
  localparam logic [BCNT_W-1:0]  LAST_BYTE = BCNT_W'(DWORD / BYTE - 1);
  localparam logic [RB_ADDR-1:0] RB_MAX    = '1;
  localparam logic [DM_ADDR-1:0] DM_MAX    = '1;

  typedef enum logic [3:0] {
    IDLE, PC_LOAD, RB_REQ, RB_WAIT, DM_REQ, DM_WAIT, SEND, WAIT_TX, DONE
  } state_e;

  typedef enum logic [1:0] { PH_PC, PH_RB, PH_DM } phase_e;

  state_e             state_q;
  phase_e             phase_q;
  logic [DWORD-1:0]   shift_q;
  logic [BCNT_W-1:0]  byte_cnt_q;
  logic [RB_ADDR-1:0] rb_cnt_q;
  logic [DM_ADDR-1:0] dm_cnt_q;

  // Sequencer FSM with registered outputs
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q              <= IDLE;
      phase_q              <= PH_PC;
      shift_q              <= '0;
      byte_cnt_q           <= '0;
      rb_cnt_q             <= '0;
      dm_cnt_q             <= '0;
      bus.o_rb_addr        <= '0;
      bus.o_rb_read_enable <= 1'b0;
      bus.o_dm_addr        <= '0;
      bus.o_dm_read_enable <= 1'b0;
      bus.o_dm_du_flag     <= 1'b0;
      bus.o_tx_data        <= '0;
      bus.o_tx_start       <= 1'b0;
      bus.o_busy           <= 1'b0;
      bus.o_done           <= 1'b0;
    end else begin
      bus.o_tx_start <= 1'b0;
      bus.o_done     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            state_q    <= PC_LOAD;
            bus.o_busy <= 1'b1;
          end
        end
        PC_LOAD: begin
          shift_q        <= bus.i_pc_value;
          byte_cnt_q     <= '0;
          phase_q        <= PH_PC;
          state_q        <= SEND;
          bus.o_tx_start <= 1'b1;
          bus.o_tx_data  <= bus.i_pc_value[DWORD-1 -: BYTE];
        end
        RB_REQ: state_q <= RB_WAIT;
        // Read data is valid one cycle after the address, i.e. in this state
        RB_WAIT: begin
          shift_q              <= bus.i_rb_data;
          byte_cnt_q           <= '0;
          state_q              <= SEND;
          bus.o_rb_read_enable <= 1'b0;
          bus.o_tx_start       <= 1'b1;
          bus.o_tx_data        <= bus.i_rb_data[DWORD-1 -: BYTE];
        end
        DM_REQ: state_q <= DM_WAIT;
        DM_WAIT: begin
          shift_q              <= bus.i_dm_data;
          byte_cnt_q           <= '0;
          state_q              <= SEND;
          bus.o_dm_read_enable <= 1'b0;
          bus.o_tx_start       <= 1'b1;
          bus.o_tx_data        <= bus.i_dm_data[DWORD-1 -: BYTE];
        end
        // i_tx_done is deliberately not looked at here
        SEND: state_q <= WAIT_TX;
        WAIT_TX: begin
          if (bus.i_tx_done) begin
            shift_q    <= shift_q << BYTE;
            byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
            if (byte_cnt_q != LAST_BYTE) begin
              state_q        <= SEND;
              bus.o_tx_start <= 1'b1;
              bus.o_tx_data  <= shift_q[DWORD-BYTE-1 -: BYTE];
            end else begin
              case (phase_q)
                PH_PC: begin
                  phase_q              <= PH_RB;
                  rb_cnt_q             <= '0;
                  bus.o_rb_addr        <= '0;
                  bus.o_rb_read_enable <= 1'b1;
                  state_q              <= RB_REQ;
                end
                PH_RB: begin
                  if (rb_cnt_q != RB_MAX) begin
                    rb_cnt_q             <= rb_cnt_q + RB_ADDR'(1);
                    bus.o_rb_addr        <= rb_cnt_q + RB_ADDR'(1);
                    bus.o_rb_read_enable <= 1'b1;
                    state_q              <= RB_REQ;
                  end else begin
                    phase_q              <= PH_DM;
                    dm_cnt_q             <= '0;
                    bus.o_dm_addr        <= '0;
                    bus.o_dm_read_enable <= 1'b1;
                    bus.o_dm_du_flag     <= 1'b1;
                    state_q              <= DM_REQ;
                  end
                end
                default: begin
                  if (dm_cnt_q != DM_MAX) begin
                    dm_cnt_q             <= dm_cnt_q + DM_ADDR'(1);
                    bus.o_dm_addr        <= dm_cnt_q + DM_ADDR'(1);
                    bus.o_dm_read_enable <= 1'b1;
                    state_q              <= DM_REQ;
                  end else begin
                    bus.o_dm_du_flag <= 1'b0;
                    bus.o_done       <= 1'b1;
                    state_q          <= DONE;
                  end
                end
              endcase
            end
          end
        end
        DONE: begin
          state_q    <= IDLE;
          bus.o_busy <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_du_dump_sequencer.sv
// Scoreboard bench for du_dump_sequencer: stimulus pushes the expected byte stream,
// a negedge monitor pops and compares on every o_tx_start and tracks read-port
// timing invariants.
module tb_du_dump_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  du_dump_sequencer_if bus ();

  du_dump_sequencer dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q [$];

  // monitor state
  int   start_cnt = 0, done_cnt = 0, first_tx_cyc = 0;
  bit   had_first = 0, lat_valid = 0, dm_phase = 0;
  logic [7:0] lat_byte = '0;
  int   rb_run = 0, dm_run = 0;
  logic prev_rb_en = 0, prev_dm_en = 0;
  logic [4:0] prev_rb_addr = '0, prev_dm_addr = '0;
  int   en_err = 0, flag_err = 0, hold_err = 0;

  // UART model controls
  int ucnt = 0;
  int slow_at = -1;
  bit spur_send = 0;
  int spur_req = 0, spur_ack = 0;

  int start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Register bank / data memory: registered read, garbage when not enabled
  always @(posedge clk) begin
    bus.i_rb_data <= bus.o_rb_read_enable ? 32'h1000_0000 + 32'(bus.o_rb_addr) : 32'hBAD0_BAD0;
    bus.i_dm_data <= (bus.o_dm_read_enable && bus.o_dm_du_flag) ?
                     32'hDEAD_0000 + 32'(bus.o_dm_addr) : 32'hBAD1_BAD1;
  end

  // UART TX model: done 10 cycles after each start (1000 for the byte at slow_at)
  initial begin
    bit skip = 0;
    int n;
    bus.i_tx_done = 1'b0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 0;
      if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        skip = 1;
      end else if (bus.o_tx_start) begin
        n = (ucnt == slow_at) ? 1000 : 10;
        ucnt++;
        if (spur_send) begin
          // high across the SEND->WAIT_TX edge only
          bus.i_tx_done = 1'b1;
          @(negedge clk);
          bus.i_tx_done = 1'b0;
          n--;
        end
        repeat (n - 1) @(negedge clk);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        skip = 1;
      end
    end
  end

  // Monitor: byte scoreboard and read-port / flag invariants
  initial begin
    forever begin
      @(negedge clk);
      if (!bus.o_busy) begin
        lat_valid = 0;
        had_first = 0;
        dm_phase  = 0;
      end
      if (bus.o_tx_start) begin
        start_cnt++;
        if (!had_first) begin
          had_first    = 1;
          first_tx_cyc = cyc;
        end
        if (exp_q.size() == 0) check("byte_extra_queue_size", 32'(exp_q.size()), 1);
        else check("byte", 32'(bus.o_tx_data), 32'(exp_q.pop_front()));
        lat_byte  = bus.o_tx_data;
        lat_valid = 1;
      end else if (lat_valid && bus.o_tx_data !== lat_byte) begin
        hold_err++;
      end
      if (bus.o_done) done_cnt++;
      // each read enable is a 2-cycle run (REQ, WAIT) with a stable address
      if (bus.o_rb_read_enable) begin
        rb_run++;
        if (prev_rb_en && bus.o_rb_addr !== prev_rb_addr) en_err++;
      end else begin
        if (rb_run != 0 && rb_run != 2) en_err++;
        rb_run = 0;
      end
      if (bus.o_dm_read_enable) begin
        dm_run++;
        if (prev_dm_en && bus.o_dm_addr !== prev_dm_addr) en_err++;
      end else begin
        if (dm_run != 0 && dm_run != 2) en_err++;
        dm_run = 0;
      end
      if (bus.o_rb_read_enable && bus.o_dm_read_enable) en_err++;
      if (bus.o_dm_read_enable) dm_phase = 1;
      if (bus.o_done) dm_phase = 0;
      if (bus.o_rb_read_enable && dm_phase) en_err++;
      if (bus.o_dm_du_flag !== dm_phase) flag_err++;
      prev_rb_en   = bus.o_rb_read_enable;
      prev_dm_en   = bus.o_dm_read_enable;
      prev_rb_addr = bus.o_rb_addr;
      prev_dm_addr = bus.o_dm_addr;
    end
  end

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic push_dump(input logic [31:0] pc);
    push_word(pc);
    for (int i = 0; i < 32; i++) push_word(32'h1000_0000 + 32'(i));
    for (int i = 0; i < 32; i++) push_word(32'hDEAD_0000 + 32'(i));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.o_busy, bus.o_done, bus.o_tx_start, bus.o_tx_data,
                bus.o_rb_read_enable, bus.o_rb_addr, bus.o_dm_read_enable,
                bus.o_dm_addr, bus.o_dm_du_flag});
  endfunction

  // Launch a dump and check the first-byte latency
  task automatic launch(input logic [31:0] pc);
    int s0;
    s0 = start_cnt;
    push_dump(pc);
    bus.i_pc_value = pc;
    pulse_start();
    start_cyc = cyc;  // cyc value right after the sampling edge N
    for (int k = 0; k < 20; k++) begin
      if (start_cnt > s0) break;
      @(negedge clk);
    end
    check("first_tx_seen", 32'(start_cnt > s0), 1);
    // o_tx_start visible in the cycle ending at edge N+2
    check("first_tx_latency", 32'(first_tx_cyc - start_cyc), 1);
  endtask

  task automatic finish_dump(input int s0, input int d0);
    for (int k = 0; k < 8000; k++) begin
      @(negedge clk);
      if (bus.o_done) break;
    end
    check("done_seen", 32'(bus.o_done), 1);
    check("busy_in_done", 32'(bus.o_busy), 1);
    @(negedge clk);
    check("busy_after_done", 32'(bus.o_busy), 0);
    check("done_one_cycle", 32'(bus.o_done), 0);
    repeat (5) @(negedge clk);
    check("tx_start_count", 32'(start_cnt - s0), 260);
    check("done_count", 32'(done_cnt - d0), 1);
    check("queue_drained", 32'(exp_q.size()), 0);
    check("read_enable_timing_errs", 32'(en_err), 0);
    check("dm_flag_errs", 32'(flag_err), 0);
    check("tx_data_hold_errs", 32'(hold_err), 0);
  endtask

  initial begin
    int s0, d0, base, sc;
    rst_n          = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_pc_value = '0;
    #12;
    check("outputs_in_reset", all_outs(), 0);
    #11 rst_n = 1'b1;
    @(negedge clk);
    check("outputs_after_reset", all_outs(), 0);

    // Dump 1: plain full dump
    s0 = start_cnt; d0 = done_cnt;
    launch(32'h0000_0A3C);
    finish_dump(s0, d0);

    // Dump 2: spurious done in IDLE and SEND, mid-dump starts, slow UART byte
    spur_req++;
    repeat (5) @(negedge clk);
    check("idle_spurious_busy", 32'(bus.o_busy), 0);
    check("idle_spurious_no_start", 32'(start_cnt), 32'(260));
    base      = ucnt;
    slow_at   = base + 2;
    spur_send = 1;
    s0 = start_cnt; d0 = done_cnt;
    launch(32'h1234_5678);
    for (int k = 0; k < 200; k++) begin
      if (ucnt >= base + 3) break;
      @(negedge clk);
    end
    check("reach_slow_byte", 32'(ucnt >= base + 3), 1);
    repeat (100) @(negedge clk);
    sc = start_cnt;
    pulse_start();
    repeat (400) @(negedge clk);
    pulse_start();
    repeat (300) @(negedge clk);
    check("slow_no_start", 32'(start_cnt), 32'(sc));
    check("slow_hold_data", 32'(bus.o_tx_data), 32'h56);
    check("slow_busy", 32'(bus.o_busy), 1);
    for (int k = 0; k < 3000; k++) begin
      if (ucnt >= base + 100) break;
      @(negedge clk);
    end
    pulse_start();
    finish_dump(s0, d0);
    spur_send = 0;
    slow_at   = -1;

    // Dump 3: asynchronous reset during the second byte of R5
    s0 = start_cnt;
    launch(32'hCAFE_F00D);
    for (int k = 0; k < 2000; k++) begin
      if (start_cnt >= s0 + 26) break;
      @(negedge clk);
    end
    check("reach_r5_byte", 32'(start_cnt >= s0 + 26), 1);
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("outputs_async_reset", all_outs(), 0);
    exp_q.delete();
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_after_reset", 32'(bus.o_busy), 0);

    // Dump 4: restart begins with the PC word
    s0 = start_cnt; d0 = done_cnt;
    launch(32'h0000_0001);
    finish_dump(s0, d0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
